shield_oc_fault_monitor: RTL and testbench



---
 rtl/shield_oc_pkg.sv | 40 ++++
 rtl/shield_oc_debounce.sv | 52 +++++
 rtl/shield_oc_fault_monitor.sv | 218 +++++++++++++++++++++
 tb/tb_shield_oc_fault_monitor.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shield_oc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shield_oc_pkg
//  Purpose  : Shared types and constants for the shield over-current monitor:
//             channel FSM states, register map and fault-counter helper.
//  Revision : 1.0  initial release
// ============================================================================
package shield_oc_pkg;

    localparam int c_FCNT_W = 8;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_BLANK = 3'd1,
        ST_RUN   = 3'd2,
        ST_FAULT = 3'd3,
        ST_RETRY = 3'd4
    } oc_state_t;

    // Register addresses
    localparam logic c_ADDR_CTRL = 1'b0;
    localparam logic c_ADDR_CNT  = 1'b1;

    // Register 0 field positions (two bits each, B above A)
    localparam int c_BIT_LATCH = 0;
    localparam int c_BIT_OC    = 8;
    localparam int c_BIT_PWR   = 16;
    localparam int c_BIT_IRQEN = 24;

    // Register 1 byte lanes for the per-channel counters
    localparam int c_BIT_CNT_A = 0;
    localparam int c_BIT_CNT_B = 8;

    // Saturating increment so a chattering fault cannot wrap the count
    function automatic logic [c_FCNT_W-1:0] sat_inc(input logic [c_FCNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shield_oc_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : shield_oc_debounce
//  Purpose  : Two-flop synchroniser followed by a level debouncer for one
//             active-low over-current pin. The clean level changes only after
//             DEBOUNCE_CYCLES consecutive synchronised samples disagree with
//             it, giving 2 + DEBOUNCE_CYCLES cycles from pin edge to output.
//  Revision : 1.0  initial release
// ============================================================================
module shield_oc_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level
);

    localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]        r_sync;
    logic              r_level;
    logic [c_DB_W-1:0] r_cnt;

    // Bring the asynchronous pin into the clock domain; preset high (no OC)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_raw};
        end
    end

    // Count consecutive disagreeing samples; any agreeing sample restarts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else if (r_sync[1] == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == c_DB_W'(DEBOUNCE_CYCLES - 1)) begin
            r_level <= r_sync[1];
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/shield_oc_fault_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : shield_oc_fault_monitor
//  Purpose  : Conditions the shield OCN pins, gates the active-low power
//             enables of modules A and B, latches over-current faults with an
//             Avalon-MM status/clear/interrupt-enable interface and per-channel
//             saturating fault counters. Every power-on starts an inrush
//             blanking window during which OC is ignored.
//             Build option: define SHIELD_OC_AUTORETRY_EN to add a timed
//             RETRY state after each fault (default: fault is sticky until a
//             software clear).
//  Revision : 1.0  initial release
// ============================================================================
module shield_oc_fault_monitor
    import shield_oc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int BLANK_CYCLES    = 50000,
    parameter int RETRY_CYCLES    = 5000000,
    parameter int CNT_W           = 24
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset_n,
    input  logic        avs_Fault_address,
    input  logic [31:0] avs_Fault_writedata,
    output logic [31:0] avs_Fault_readdata,
    input  logic [3:0]  avs_Fault_byteenable,
    input  logic        avs_Fault_write,
    input  logic        avs_Fault_read,
    output logic        avs_Fault_waitrequest,
    output logic        ins_Fault_irq,
    input  logic        coe_A_OCN_raw,
    input  logic        coe_B_OCN_raw,
    input  logic        coe_A_PWREN_req,
    input  logic        coe_B_PWREN_req,
    output logic        coe_A_OCN,
    output logic        coe_B_OCN,
    output logic        coe_A_PWREN,
    output logic        coe_B_PWREN
);

    logic [1:0]                 w_raw;
    logic [1:0]                 w_req;
    logic [1:0]                 w_level;
    logic [1:0]                 w_oc;
    logic [1:0]                 w_latch;
    logic [1:0]                 w_pwren;
    logic [1:0][c_FCNT_W-1:0]   w_fcnt;
    logic                       w_wr_ctrl;
    logic [1:0]                 w_clr;
    logic                       w_cnt_clr;
    logic [1:0]                 r_irq_en;
    logic                       r_irq;

    assign w_raw = {coe_B_OCN_raw, coe_A_OCN_raw};
    assign w_req = {coe_B_PWREN_req, coe_A_PWREN_req};
    assign w_oc  = ~w_level;

    assign w_wr_ctrl = avs_Fault_write && (avs_Fault_address == c_ADDR_CTRL);
    assign w_clr     = (w_wr_ctrl && avs_Fault_byteenable[0])
                       ? avs_Fault_writedata[c_BIT_LATCH +: 2] : 2'b00;
    assign w_cnt_clr = avs_Fault_write && (avs_Fault_address == c_ADDR_CNT)
                       && avs_Fault_byteenable[0];

    // The read strobe has no side effects, so readdata depends on address only
    assign avs_Fault_waitrequest = 1'b0;

    for (genvar g = 0; g < 2; g++) begin : g_ch
        oc_state_t              r_state;
        logic [CNT_W-1:0]       r_timer;
        logic                   r_pwren;
        logic                   r_latch;
        logic [c_FCNT_W-1:0]    r_fcnt;
        logic                   w_fault_evt;

        shield_oc_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (csi_MCLK_clk),
            .rst_n   (rsi_MRST_reset_n),
            .i_raw   (w_raw[g]),
            .o_level (w_level[g])
        );

        // A fault is only qualified once blanking is over
        assign w_fault_evt = (r_state == ST_RUN) && w_oc[g];

        // Channel power sequencing, fault latch and fault counter
        always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
            if (!rsi_MRST_reset_n) begin
                r_state <= ST_OFF;
                r_timer <= '0;
                r_pwren <= 1'b1;
                r_latch <= 1'b0;
                r_fcnt  <= '0;
            end else begin
                // A new fault beats a simultaneous clear; a clear is also
                // refused while the pin still reports over-current
                if (w_fault_evt) begin
                    r_latch <= 1'b1;
                end else if (w_clr[g] && !w_oc[g]) begin
                    r_latch <= 1'b0;
                end

                if (w_fault_evt) begin
                    r_fcnt <= w_cnt_clr ? c_FCNT_W'(1) : sat_inc(r_fcnt);
                end else if (w_cnt_clr) begin
                    r_fcnt <= '0;
                end

                case (r_state)
                    ST_OFF: begin
                        if (!w_req[g]) begin
                            r_state <= ST_BLANK;
                            r_timer <= '0;
                            r_pwren <= 1'b0;
                        end
                    end
                    ST_BLANK: begin
                        if (w_req[g]) begin
                            r_state <= ST_OFF;
                            r_pwren <= 1'b1;
                        end else if (r_timer == CNT_W'(BLANK_CYCLES - 1)) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        // Fault takes precedence so a real OC is always logged
                        if (w_oc[g]) begin
                            r_state <= ST_FAULT;
                            r_pwren <= 1'b1;
                        end else if (w_req[g]) begin
                            r_state <= ST_OFF;
                            r_pwren <= 1'b1;
                        end
                    end
                    ST_FAULT: begin
`ifdef SHIELD_OC_AUTORETRY_EN
                        r_state <= ST_RETRY;
                        r_timer <= '0;
`else
                        if (!r_latch) begin
                            if (w_req[g]) begin
                                r_state <= ST_OFF;
                            end else begin
                                r_state <= ST_BLANK;
                                r_timer <= '0;
                                r_pwren <= 1'b0;
                            end
                        end
`endif
                    end
`ifdef SHIELD_OC_AUTORETRY_EN
                    ST_RETRY: begin
                        // Off-time runs to completion even if software clears
                        if (r_timer == CNT_W'(RETRY_CYCLES - 1)) begin
                            if (!w_req[g] && !w_oc[g]) begin
                                r_state <= ST_BLANK;
                                r_timer <= '0;
                                r_pwren <= 1'b0;
                            end else begin
                                r_state <= ST_OFF;
                            end
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
`endif
                    default: begin
                        r_state <= ST_OFF;
                        r_pwren <= 1'b1;
                    end
                endcase
            end
        end

        assign w_latch[g] = r_latch;
        assign w_pwren[g] = r_pwren;
        assign w_fcnt[g]  = r_fcnt;
    end

    // Interrupt enable register and registered level interrupt
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            r_irq_en <= 2'b11;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_ctrl && avs_Fault_byteenable[3]) begin
                r_irq_en <= avs_Fault_writedata[c_BIT_IRQEN +: 2];
            end
            r_irq <= |(w_latch & r_irq_en);
        end
    end

    // Combinational register read mux
    always_comb begin
        avs_Fault_readdata = '0;
        if (avs_Fault_address == c_ADDR_CTRL) begin
            avs_Fault_readdata[c_BIT_LATCH +: 2] = w_latch;
            avs_Fault_readdata[c_BIT_OC    +: 2] = w_oc;
            avs_Fault_readdata[c_BIT_PWR   +: 2] = ~w_pwren;
            avs_Fault_readdata[c_BIT_IRQEN +: 2] = r_irq_en;
        end else begin
            avs_Fault_readdata[c_BIT_CNT_A +: c_FCNT_W] = w_fcnt[0];
            avs_Fault_readdata[c_BIT_CNT_B +: c_FCNT_W] = w_fcnt[1];
        end
    end

    assign ins_Fault_irq = r_irq;
    assign coe_A_OCN     = w_level[0];
    assign coe_B_OCN     = w_level[1];
    assign coe_A_PWREN   = w_pwren[0];
    assign coe_B_PWREN   = w_pwren[1];

endmodule
`default_nettype wire

// File: tb/tb_shield_oc_fault_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shield_oc_fault_monitor
//  Purpose  : Self-checking bench for shield_oc_fault_monitor with shortened
//             timing parameters. Expected register values are queued when the
//             stimulus is applied and popped when the DUT is read.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shield_oc_fault_monitor;

    localparam int DEB = 8;
    localparam int BLK = 40;
    localparam int RET = 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        addr = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [3:0]  be = '0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic        waitreq;
    logic        irq;
    logic        a_raw = 1'b1, b_raw = 1'b1, a_req = 1'b1, b_req = 1'b1;
    logic        a_ocn, b_ocn, a_pwr, b_pwr;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    shield_oc_fault_monitor #(
        .DEBOUNCE_CYCLES (DEB),
        .BLANK_CYCLES    (BLK),
        .RETRY_CYCLES    (RET),
        .CNT_W           (16)
    ) dut (
        .csi_MCLK_clk          (clk),
        .rsi_MRST_reset_n      (rst_n),
        .avs_Fault_address     (addr),
        .avs_Fault_writedata   (wdata),
        .avs_Fault_readdata    (rdata),
        .avs_Fault_byteenable  (be),
        .avs_Fault_write       (wr),
        .avs_Fault_read        (rd),
        .avs_Fault_waitrequest (waitreq),
        .ins_Fault_irq         (irq),
        .coe_A_OCN_raw         (a_raw),
        .coe_B_OCN_raw         (b_raw),
        .coe_A_PWREN_req       (a_req),
        .coe_B_PWREN_req       (b_req),
        .coe_A_OCN             (a_ocn),
        .coe_B_OCN             (b_ocn),
        .coe_A_PWREN           (a_pwr),
        .coe_B_PWREN           (b_pwr)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reg_rd(input logic a, output logic [31:0] d);
        addr = a; rd = 1'b1;
        #1;
        d = rdata; rd = 1'b0;
    endtask

    task automatic reg_wr(input logic a, input logic [31:0] d, input logic [3:0] b);
        addr = a; wdata = d; be = b; wr = 1'b1;
        tick();
        wr = 1'b0; be = '0; wdata = '0;
    endtask

    task automatic test_reset;
        logic [31:0] d, e;
        rst_n = 1'b0; tick(3); rst_n = 1'b1; tick();
        checks++; if ({b_pwr, a_pwr} !== 2'b11) begin failures++; $display("FAIL reset_pwren got=%b exp=11", {b_pwr, a_pwr}); end
        checks++; if ({b_ocn, a_ocn} !== 2'b11) begin failures++; $display("FAIL reset_ocn got=%b exp=11", {b_ocn, a_ocn}); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++; if (waitreq !== 1'b0) begin failures++; $display("FAIL waitreq got=%b exp=0", waitreq); end
        sb_q.push_back(32'h0300_0000); reg_rd(1'b0, d); e = sb_q.pop_front();
        checks++; if (d !== e) begin failures++; $display("FAIL reset_reg0 got=%h exp=%h", d, e); end
        sb_q.push_back(32'h0000_0000); reg_rd(1'b1, d); e = sb_q.pop_front();
        checks++; if (d !== e) begin failures++; $display("FAIL reset_reg1 got=%h exp=%h", d, e); end
    endtask

    task automatic test_blanking;
        logic [31:0] d, e;
        a_req = 1'b0; tick();
        checks++; if (a_pwr !== 1'b0) begin failures++; $display("FAIL power_on_latency got=%b exp=0", a_pwr); end
        tick(10); a_raw = 1'b0; tick(12); a_raw = 1'b1; tick(3);
        checks++; if (a_ocn !== 1'b0) begin failures++; $display("FAIL blank_ocn_seen got=%b exp=0", a_ocn); end
        checks++; if (a_pwr !== 1'b0) begin failures++; $display("FAIL blank_no_trip got=%b exp=0", a_pwr); end
        tick(20);
        sb_q.push_back(32'h0301_0000); reg_rd(1'b0, d); e = sb_q.pop_front();
        checks++; if (d !== e) begin failures++; $display("FAIL blank_reg0 got=%h exp=%h", d, e); end
    endtask

    task automatic test_glitch;
        logic [31:0] d, e;
        int bad = 0;
        b_req = 1'b0; tick(BLK + 5);
        b_raw = 1'b0; tick(DEB - 1); b_raw = 1'b1;
        for (int i = 0; i < DEB + 6; i++) begin
            if (b_ocn !== 1'b1) bad++;
            tick();
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL glitch_ocn low_cycles=%0d exp=0", bad); end
        checks++; if (b_pwr !== 1'b0) begin failures++; $display("FAIL glitch_pwren got=%b exp=0", b_pwr); end
        sb_q.push_back(32'h0303_0000); reg_rd(1'b0, d); e = sb_q.pop_front();
        checks++; if (d !== e) begin failures++; $display("FAIL glitch_reg0 got=%h exp=%h", d, e); end
    endtask

    task automatic test_fault;
        logic [31:0] d, e;
        a_raw = 1'b0; tick(DEB + 2);
        checks++; if (a_pwr !== 1'b0) begin failures++; $display("FAIL fault_early got=%b exp=0", a_pwr); end
        tick();
        checks++; if (a_pwr !== 1'b1) begin failures++; $display("FAIL fault_cut got=%b exp=1", a_pwr); end
        tick();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL fault_irq got=%b exp=1", irq); end
        sb_q.push_back(32'h0302_0101); reg_rd(1'b0, d); e = sb_q.pop_front();
        checks++; if (d !== e) begin failures++; $display("FAIL fault_reg0 got=%h exp=%h", d, e); end
        sb_q.push_back(32'h0000_0001); reg_rd(1'b1, d); e = sb_q.pop_front();
        checks++; if (d !== e) begin failures++; $display("FAIL fault_reg1 got=%h exp=%h", d, e); end
    endtask

`ifndef SHIELD_OC_AUTORETRY_EN
    task automatic test_w1c;
        logic [31:0] d, e;
        reg_wr(1'b0, 32'h1, 4'b0001);
        sb_q.push_back(32'h0302_0101); reg_rd(1'b0, d); e = sb_q.pop_front();
        checks++; if (d !== e) begin failures++; $display("FAIL clr_during_oc got=%h exp=%h", d, e); end
        a_raw = 1'b1; tick(DEB + 4);
        checks++; if (a_pwr !== 1'b1) begin failures++; $display("FAIL fault_sticky got=%b exp=1", a_pwr); end
        reg_wr(1'b0, 32'h1, 4'b0001);
        checks++; if (a_pwr !== 1'b1) begin failures++; $display("FAIL clr_latency got=%b exp=1", a_pwr); end
        tick();
        checks++; if (a_pwr !== 1'b0) begin failures++; $display("FAIL clr_reblank got=%b exp=0", a_pwr); end
        sb_q.push_back(32'h0303_0000); reg_rd(1'b0, d); e = sb_q.pop_front();
        checks++; if (d !== e) begin failures++; $display("FAIL clr_reg0 got=%h exp=%h", d, e); end
    endtask

    task automatic test_clear_vs_fault;
        logic [31:0] d, e;
        tick(BLK + 2);
        a_raw = 1'b0; tick(DEB + 2);
        addr = 1'b0; wdata = 32'h1; be = 4'b0001; wr = 1'b1;
        tick();
        wr = 1'b0; be = '0; wdata = '0;
        checks++; if (a_pwr !== 1'b1) begin failures++; $display("FAIL same_cycle_cut got=%b exp=1", a_pwr); end
        sb_q.push_back(32'h0302_0101); reg_rd(1'b0, d); e = sb_q.pop_front();
        checks++; if (d !== e) begin failures++; $display("FAIL same_cycle_reg0 got=%h exp=%h", d, e); end
        sb_q.push_back(32'h0000_0002); reg_rd(1'b1, d); e = sb_q.pop_front();
        checks++; if (d !== e) begin failures++; $display("FAIL same_cycle_reg1 got=%h exp=%h", d, e); end
    endtask

    task automatic test_irq_en;
        logic [31:0] d, e;
        tick();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_before_mask got=%b exp=1", irq); end
        reg_wr(1'b0, 32'h0, 4'b1000);
        tick();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_masked got=%b exp=0", irq); end
        sb_q.push_back(32'h0002_0101); reg_rd(1'b0, d); e = sb_q.pop_front();
        checks++; if (d !== e) begin failures++; $display("FAIL mask_reg0 got=%h exp=%h", d, e); end
    endtask

    task automatic test_reset_in_fault;
        logic [31:0] d, e;
        rst_n = 1'b0; #1;
        checks++; if ({b_pwr, a_pwr} !== 2'b11) begin failures++; $display("FAIL async_rst_pwren got=%b exp=11", {b_pwr, a_pwr}); end
        checks++; if ({b_ocn, a_ocn, irq} !== 3'b110) begin failures++; $display("FAIL async_rst_ocn_irq got=%b exp=110", {b_ocn, a_ocn, irq}); end
        sb_q.push_back(32'h0300_0000); reg_rd(1'b0, d); e = sb_q.pop_front();
        checks++; if (d !== e) begin failures++; $display("FAIL async_rst_reg0 got=%h exp=%h", d, e); end
        sb_q.push_back(32'h0000_0000); reg_rd(1'b1, d); e = sb_q.pop_front();
        checks++; if (d !== e) begin failures++; $display("FAIL async_rst_reg1 got=%h exp=%h", d, e); end
        tick(3);
        checks++; if ({b_pwr, a_pwr} !== 2'b11) begin failures++; $display("FAIL rst_hold_pwren got=%b exp=11", {b_pwr, a_pwr}); end
        a_raw = 1'b1; rst_n = 1'b1; tick();
    endtask
`else
    task automatic test_retry;
        logic [31:0] d, e;
        int n;
        rst_n = 1'b0; a_raw = 1'b1; b_raw = 1'b1; a_req = 1'b1; b_req = 1'b1;
        tick(2); rst_n = 1'b1; tick();
        a_req = 1'b0; tick(BLK + 3);
        a_raw = 1'b0; tick(DEB + 3);
        checks++; if (a_pwr !== 1'b1) begin failures++; $display("FAIL retry_cut got=%b exp=1", a_pwr); end
        a_raw = 1'b1;
        n = 0;
        while (a_pwr === 1'b1 && n < RET + 20) begin tick(); n++; end
        checks++; if (n != RET + 1) begin failures++; $display("FAIL retry_off_time got=%0d exp=%0d", n, RET + 1); end
        sb_q.push_back(32'h0301_0001); reg_rd(1'b0, d); e = sb_q.pop_front();
        checks++; if (d !== e) begin failures++; $display("FAIL retry_reg0 got=%h exp=%h", d, e); end
        sb_q.push_back(32'h0000_0001); reg_rd(1'b1, d); e = sb_q.pop_front();
        checks++; if (d !== e) begin failures++; $display("FAIL retry_reg1 got=%h exp=%h", d, e); end
    endtask

    task automatic test_retry_saturate;
        logic [31:0] d, e;
        int n;
        reg_wr(1'b1, 32'h0, 4'b0001);
        a_raw = 1'b0;
        n = 0; reg_rd(1'b1, d);
        while (d[7:0] != 8'd1 && n < 400) begin tick(); n++; reg_rd(1'b1, d); end
        n = 0;
        while (d[7:0] == 8'd1 && n < 400) begin tick(); n++; reg_rd(1'b1, d); end
        sb_q.push_back(32'h0000_0002); e = sb_q.pop_front();
        checks++; if (d !== e) begin failures++; $display("FAIL retry_step got=%h exp=%h", d, e); end
        n = 0;
        while (d[7:0] != 8'hFF && n < 40000) begin tick(); n++; reg_rd(1'b1, d); end
        tick(4 * (BLK + RET));
        sb_q.push_back(32'h0000_00FF); reg_rd(1'b1, d); e = sb_q.pop_front();
        checks++; if (d !== e) begin failures++; $display("FAIL retry_saturate got=%h exp=%h", d, e); end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_blanking();
        test_glitch();
        test_fault();
`ifndef SHIELD_OC_AUTORETRY_EN
        test_w1c();
        test_clear_vs_fault();
        test_irq_en();
        test_reset_in_fault();
`else
        test_retry();
        test_retry_saturate();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
